// File: rtl/debounce_pkg.sv
// Sizing and parameter-legality helpers for the input debouncer.
package debounce_pkg;

  function automatic int cnt_width(input int stable_ticks);
    return math_pkg::vect_range(stable_ticks) + 1;
  endfunction

  function automatic bit params_ok(input int stable_ticks, input int sync_stages);
    return (stable_ticks >= 1) && (sync_stages >= 2);
  endfunction

endpackage

// File: rtl/math_pkg.sv
// Shared arithmetic helpers for sizing vectors at elaboration time.
package math_pkg;

  // Highest bit index of a vector able to hold values 0..n-1 (0 for n<=2).
  function automatic int vect_range(input int n);
    return (n <= 2) ? 0 : $clog2(n) - 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: synchroniser, consecutive-tick counter, accepted level and
// optional edge pulses (generated only when DEBOUNCE_EDGE_PULSE_EN is defined).
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic din_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   s;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_q, rise_d, fall_q, fall_d;
`endif

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din_i};
    level_d = level_q;
    cnt_d   = cnt_q;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    rise_d  = 1'b0;
    fall_d  = 1'b0;
`endif
    if (tick) begin
      if (s == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        // Enough consecutive differing samples: accept the new level.
        level_d = s;
        cnt_d   = '0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
        rise_d  = s;
        fall_d  = ~s;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
`ifdef DEBOUNCE_EDGE_PULSE_EN
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`endif
    end
  end

  assign dout_o = level_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel tick-paced debouncer; edge pulses exist only when the
// DEBOUNCE_EDGE_PULSE_EN macro is defined, otherwise rise/fall read as 0.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int NB_INPUTS    = 1,
  parameter int STABLE_TICKS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [NB_INPUTS-1:0] din,
  output logic [NB_INPUTS-1:0] dout,
  output logic [NB_INPUTS-1:0] rise,
  output logic [NB_INPUTS-1:0] fall
);

  if (!params_ok(STABLE_TICKS, SYNC_STAGES)) begin : g_param_check
    $error("input_debouncer: need STABLE_TICKS >= 1 and SYNC_STAGES >= 2");
  end

  for (genvar i = 0; i < NB_INPUTS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_channel (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .din_i  (din[i]),
      .dout_o (dout[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

endmodule
